// File: rtl/gpio_reg_controller_if.sv
// PS GPIO bus: write word toward the controller, readback/status back.
interface gpio_reg_controller_if #(
   parameter int REG_WIDTH = 32
);
   logic [31:0]          gpio_in;
   logic [REG_WIDTH-1:0] gpio_out;
   logic                 wr_ack;
   logic                 overrun;

   modport master (
      output gpio_in,
      input  gpio_out,
      input  wr_ack,
      input  overrun
   );

   modport slave (
      input  gpio_in,
      output gpio_out,
      output wr_ack,
      output overrun
   );
endinterface

// File: rtl/gpio_reg_controller.sv
// GPIO write sequencer: byte staging into config registers,
// explicit commit, and datapath readback snapshot.
module gpio_reg_controller #(
   parameter int REG_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gpio_reg_controller_if.slave bus,
   input  logic [REG_WIDTH-1:0] x_out,
   input  logic [REG_WIDTH-1:0] y_out,
   input  logic [REG_WIDTH-1:0] sin_out,
   input  logic [REG_WIDTH-1:0] cos_out,
   output logic [REG_WIDTH-1:0] user_cntr,
   output logic [REG_WIDTH-1:0] sinc_in,
   output logic [REG_WIDTH-1:0] inc_in,
   output logic [REG_WIDTH-1:0] mul_scalar,
   output logic [3:0]           reg_upd
);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DECODE
   } state_t;

   state_t               state;
   logic [24:0]          s1;
   logic [24:0]          s2;
   logic                 s3;
   logic [3:0]           lane_q;
   logic [11:0]          reg_q;
   logic [7:0]           data_q;
   logic [1:0]           sel;
   logic [REG_WIDTH-1:0] staging;
   logic [REG_WIDTH-1:0] pick;
   logic                 rise;
   logic                 is_cfg;
   logic                 is_sel;
   logic                 lane_ok;
   logic                 unused_hi;

   assign unused_hi = ^bus.gpio_in[31:25];
   assign rise      = s2[24] & ~s3;
   assign is_cfg    = (reg_q[11:2] == 10'd0);
   assign is_sel    = (reg_q == 12'h0FF);

   always_comb begin
      lane_ok = 1'b0;
      for (int i = 0; i < REG_WIDTH / 8; i++)
         if (lane_q == i[3:0])
            lane_ok = 1'b1;
   end

   always_comb begin
      pick = x_out;
      unique case (data_q[1:0])
         2'd0: pick = x_out;
         2'd1: pick = y_out;
         2'd2: pick = sin_out;
         2'd3: pick = cos_out;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         s1           <= '0;
         s2           <= '0;
         s3           <= 1'b0;
         lane_q       <= '0;
         reg_q        <= '0;
         data_q       <= '0;
         sel          <= '0;
         staging      <= '0;
         user_cntr    <= '0;
         sinc_in      <= '0;
         inc_in       <= '0;
         mul_scalar   <= '0;
         reg_upd      <= '0;
         bus.gpio_out <= '0;
         bus.wr_ack   <= 1'b0;
         bus.overrun  <= 1'b0;
      end else begin
         s1      <= bus.gpio_in[24:0];
         s2      <= s1;
         s3      <= s2[24];
         reg_upd <= '0;
         unique case (state)
            IDLE: begin
               if (rise) begin
                  state  <= CAPTURE;
                  lane_q <= s2[15:12];
                  reg_q  <= s2[11:0];
                  data_q <= s2[23:16];
               end
            end
            CAPTURE: begin
               // the write action lands on the edge entering DECODE
               if (rise)
                  bus.overrun <= 1'b1;
               state      <= DECODE;
               bus.wr_ack <= ~bus.wr_ack;
               unique case (1'b1)
                  is_cfg: begin
                     if (lane_q == 4'hF) begin
                        reg_upd <= 4'b0001 << reg_q[1:0];
                        unique case (reg_q[1:0])
                           2'd0: user_cntr  <= staging;
                           2'd1: sinc_in    <= staging;
                           2'd2: inc_in     <= staging;
                           2'd3: mul_scalar <= staging;
                        endcase
                     end else if (lane_ok) begin
                        for (int i = 0; i < REG_WIDTH / 8; i++)
                           if (lane_q == i[3:0])
                              staging[i*8 +: 8] <= data_q;
                     end
                  end
                  is_sel: begin
                     sel          <= data_q[1:0];
                     bus.gpio_out <= pick;
                  end
                  default: ;
               endcase
            end
            DECODE: begin
               if (rise)
                  bus.overrun <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_reg_controller.sv
// Scoreboard bench for gpio_reg_controller: writes push expectations,
// an ack-driven monitor pops and compares.
module tb_gpio_reg_controller;

   logic        clk;
   logic        rst_n;
   logic [31:0] x_out;
   logic [31:0] y_out;
   logic [31:0] sin_out;
   logic [31:0] cos_out;
   logic [31:0] user_cntr;
   logic [31:0] sinc_in;
   logic [31:0] inc_in;
   logic [31:0] mul_scalar;
   logic [3:0]  reg_upd;

   gpio_reg_controller_if #(.REG_WIDTH(32)) bus ();

   gpio_reg_controller #(.REG_WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .x_out      (x_out),
      .y_out      (y_out),
      .sin_out    (sin_out),
      .cos_out    (cos_out),
      .user_cntr  (user_cntr),
      .sinc_in    (sinc_in),
      .inc_in     (inc_in),
      .mul_scalar (mul_scalar),
      .reg_upd    (reg_upd)
   );

   typedef struct {
      logic [31:0] uc;
      logic [31:0] si;
      logic [31:0] ii;
      logic [31:0] ms;
      logic [31:0] go;
      logic [3:0]  upd;
      logic        ov;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   total = 0;
   int   bad = 0;
   int   acks = 0;
   int   upd_cycles = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin : monitor
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = 1'b0;
         end else begin
            if (reg_upd != 4'd0)
               upd_cycles++;
            if (bus.wr_ack !== prev) begin
               prev = bus.wr_ack;
               acks++;
               if (q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_ack: got ack %0d expected none",
                           acks);
               end else begin
                  e = q.pop_front();
                  chk("user_cntr", user_cntr, e.uc);
                  chk("sinc_in", sinc_in, e.si);
                  chk("inc_in", inc_in, e.ii);
                  chk("mul_scalar", mul_scalar, e.ms);
                  chk("gpio_out", bus.gpio_out, e.go);
                  chk("reg_upd", {28'd0, reg_upd}, {28'd0, e.upd});
                  chk("overrun", {31'd0, bus.overrun}, {31'd0, e.ov});
               end
            end
         end
      end
   end

   task automatic wr(input logic [3:0] lane, input logic [11:0] rg,
                     input logic [7:0] data);
      @(negedge clk);
      bus.gpio_in = {7'd0, 1'b1, data, lane, rg};
      repeat (3) @(negedge clk);
      bus.gpio_in[24] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic push_w(input logic [3:0] lane, input logic [11:0] rg,
                         input logic [7:0] data, input logic [3:0] upd);
      cur.upd = upd;
      q.push_back(cur);
      wr(lane, rg, data);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_uc"}, user_cntr, 32'd0);
      chk({tag, "_si"}, sinc_in, 32'd0);
      chk({tag, "_ii"}, inc_in, 32'd0);
      chk({tag, "_ms"}, mul_scalar, 32'd0);
      chk({tag, "_go"}, bus.gpio_out, 32'd0);
      chk({tag, "_upd"}, {28'd0, reg_upd}, 32'd0);
      chk({tag, "_ack"}, {31'd0, bus.wr_ack}, 32'd0);
      chk({tag, "_ov"}, {31'd0, bus.overrun}, 32'd0);
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.gpio_in = 32'd0;
      x_out       = 32'h1111_1111;
      y_out       = 32'h0;
      sin_out     = 32'h5151_5151;
      cos_out     = 32'hCAFE_F00D;
      cur         = '{default: '0};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.gpio_in = {7'd0, i[0], 8'hAB, 4'hF, 12'h002};
      end
      bus.gpio_in = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk_zero("reset");

      push_w(4'h0, 12'h002, 8'h78, 4'b0000);
      push_w(4'h1, 12'h002, 8'h56, 4'b0000);
      push_w(4'h2, 12'h002, 8'h34, 4'b0000);
      push_w(4'h3, 12'h002, 8'h12, 4'b0000);
      cur.ii = 32'h1234_5678;
      push_w(4'hF, 12'h002, 8'h00, 4'b0100);
      cur.ms = 32'h1234_5678;
      push_w(4'hF, 12'h003, 8'h00, 4'b1000);
      push_w(4'h0, 12'h000, 8'h01, 4'b0000);
      cur.uc = 32'h1234_5601;
      push_w(4'hF, 12'h000, 8'h00, 4'b0001);

      y_out  = 32'hDEAD_BEEF;
      cur.go = 32'hDEAD_BEEF;
      push_w(4'h0, 12'h0FF, 8'h01, 4'b0000);
      y_out = 32'h0BAD_F00D;
      repeat (3) @(negedge clk);
      chk("gpio_out_held", bus.gpio_out, 32'hDEAD_BEEF);

      push_w(4'h0, 12'h123, 8'hAA, 4'b0000);
      push_w(4'h5, 12'h001, 8'h55, 4'b0000);
      cur.si = 32'h1234_5601;
      push_w(4'hF, 12'h001, 8'h00, 4'b0010);
      cur.go = 32'hCAFE_F00D;
      push_w(4'h3, 12'h0FF, 8'h03, 4'b0000);

      cur.go  = 32'h5151_5151;
      cur.upd = 4'b0000;
      q.push_back(cur);
      @(negedge clk);
      bus.gpio_in = {7'd0, 1'b1, 8'h02, 4'h0, 12'h0FF};
      @(negedge clk);
      bus.gpio_in[24] = 1'b0;
      @(negedge clk);
      bus.gpio_in = {7'd0, 1'b1, 8'h00, 4'hF, 12'h000};
      @(negedge clk);
      bus.gpio_in[24] = 1'b0;
      repeat (8) @(negedge clk);
      chk("overrun_set", {31'd0, bus.overrun}, 32'd1);
      chk("uc_after_drop", user_cntr, 32'h1234_5601);
      repeat (4) @(negedge clk);
      chk("overrun_held", {31'd0, bus.overrun}, 32'd1);
      chk("ack_count", acks, 32'd14);
      chk("upd_cycles", upd_cycles, 32'd4);
      chk("queue_empty", q.size(), 32'd0);

      @(negedge clk);
      bus.gpio_in = {7'd0, 1'b1, 8'h00, 4'hF, 12'h003};
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      bus.gpio_in = 32'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk_zero("abort");
      chk("abort_acks", acks, 32'd14);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
